// File: rtl/neuron_pkg.sv
// ============================================================================
// Module      : neuron_pkg
// Description : Shared constants, FSM state type and saturating adder for the
//               neuron pipeline stages.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package neuron_pkg;

    localparam int XDATA_WIDTH       = 10;
    localparam int XDATA_PREC        = 5;
    localparam int WDATA_WIDTH       = 11;
    localparam int WDATA_PREC        = 5;
    localparam int ACC_WIDTH         = 24;
    localparam int PROD_WIDTH        = XDATA_WIDTH + WDATA_WIDTH;
    localparam int MAX_TERMS_DEFAULT = 64;

    typedef enum logic [1:0] {
        ST_ACC = 2'd0,
        ST_FIN = 2'd1,
        ST_OUT = 2'd2
    } state_t;

    typedef struct packed {
        logic                 sat;
        logic [ACC_WIDTH-1:0] sum;
    } sat_sum_t;

    // Signed add clamped to the ACC_WIDTH range; sat flags a clamp.
    function automatic sat_sum_t sat_add(input logic [ACC_WIDTH-1:0] a,
                                         input logic [ACC_WIDTH-1:0] b);
        logic [ACC_WIDTH:0] w_full;
        sat_sum_t           r;
        w_full = {a[ACC_WIDTH-1], a} + {b[ACC_WIDTH-1], b};
        r.sat  = w_full[ACC_WIDTH] ^ w_full[ACC_WIDTH-1];
        if (!r.sat)
            r.sum = w_full[ACC_WIDTH-1:0];
        else if (w_full[ACC_WIDTH])
            r.sum = {1'b1, {(ACC_WIDTH-1){1'b0}}};
        else
            r.sum = {1'b0, {(ACC_WIDTH-1){1'b1}}};
        return r;
    endfunction

endpackage

`default_nettype wire

// File: rtl/neuron_requant.sv
// ============================================================================
// Module      : neuron_requant
// Description : Combinational bias add, requantize shift, ReLU and clip.
//               NEURON_ACC_ROUND_EN selects round-half-up over truncation.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module neuron_requant
    import neuron_pkg::*;
(
    input  logic [ACC_WIDTH-1:0]          acc,
    input  logic signed [WDATA_WIDTH-1:0] bias,
    input  logic                          acc_sat,
    output logic [XDATA_WIDTH-1:0]        data,
    output logic                          sat
);

    localparam logic signed [ACC_WIDTH-1:0] c_x_max =
        ACC_WIDTH'((1 << (XDATA_WIDTH-1)) - 1);

    logic [ACC_WIDTH-1:0]        w_bias_al;
    sat_sum_t                    w_biased;
    sat_sum_t                    w_rounded;
    logic signed [ACC_WIDTH-1:0] w_q;
    logic                        w_clip;

    // Bias carries WDATA_PREC fraction bits; the accumulator carries both.
    assign w_bias_al = {{(ACC_WIDTH-WDATA_WIDTH-XDATA_PREC){bias[WDATA_WIDTH-1]}},
                        bias, {XDATA_PREC{1'b0}}};
    assign w_biased  = sat_add(acc, w_bias_al);

`ifdef NEURON_ACC_ROUND_EN
    localparam logic [ACC_WIDTH-1:0] c_half = ACC_WIDTH'(1 << (WDATA_PREC-1));
    assign w_rounded = sat_add(w_biased.sum, c_half);
`else
    assign w_rounded = w_biased;
`endif

    assign w_q = $signed(w_rounded.sum) >>> WDATA_PREC;

    always_comb begin
        data   = '0;
        w_clip = 1'b0;
        if (w_q[ACC_WIDTH-1]) begin
            data = '0;
        end else if (w_q > c_x_max) begin
            data   = c_x_max[XDATA_WIDTH-1:0];
            w_clip = 1'b1;
        end else begin
            data = w_q[XDATA_WIDTH-1:0];
        end
    end

    assign sat = acc_sat | w_biased.sat | w_rounded.sat | w_clip;

endmodule

`default_nettype wire

// File: rtl/neuron_accum.sv
// ============================================================================
// Module      : neuron_accum
// Description : Streaming dot-product accumulator with bias, requantize and
//               ReLU. Optional macro NEURON_ACC_ROUND_EN enables rounding.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module neuron_accum
    import neuron_pkg::*;
#(
    parameter int MAX_TERMS = MAX_TERMS_DEFAULT
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic signed [XDATA_WIDTH-1:0] in_x,
    input  logic signed [WDATA_WIDTH-1:0] in_w,
    input  logic                          in_last,
    input  logic signed [WDATA_WIDTH-1:0] bias,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [XDATA_WIDTH-1:0]        out_data,
    output logic                          out_sat,
    output logic                          out_err
);

    localparam int                c_cnt_w   = $clog2(MAX_TERMS + 1);
    localparam logic [c_cnt_w-1:0] c_cnt_max = c_cnt_w'(MAX_TERMS);

    state_t                       r_state;
    state_t                       w_state_nxt;
    logic [ACC_WIDTH-1:0]         r_acc;
    logic signed [WDATA_WIDTH-1:0] r_bias;
    logic [c_cnt_w-1:0]           r_cnt;
    logic                         r_sat;
    logic                         r_err;
    logic                         r_in_ready;
    logic                         r_out_valid;
    logic [XDATA_WIDTH-1:0]       r_out_data;
    logic                         r_out_sat;
    logic                         r_out_err;

    logic                         w_accept;
    logic                         w_first;
    logic                         w_close;
    logic                         w_limit;
    logic [c_cnt_w-1:0]           w_cnt_nxt;
    logic signed [PROD_WIDTH-1:0] w_prod;
    logic [ACC_WIDTH-1:0]         w_prod_ext;
    sat_sum_t                     w_sum;
    logic [XDATA_WIDTH-1:0]       w_rq_data;
    logic                         w_rq_sat;

    assign w_accept   = in_valid && r_in_ready;
    assign w_first    = (r_cnt == '0);
    assign w_cnt_nxt  = w_first ? c_cnt_w'(1) : r_cnt + c_cnt_w'(1);
    assign w_limit    = (w_cnt_nxt == c_cnt_max);
    assign w_close    = in_last || w_limit;
    assign w_prod     = in_x * in_w;
    assign w_prod_ext = {{(ACC_WIDTH-PROD_WIDTH){w_prod[PROD_WIDTH-1]}}, w_prod};
    assign w_sum      = sat_add(r_acc, w_prod_ext);

    always_ff @(posedge clk) begin
        if (rst)
            r_state <= ST_ACC;
        else
            r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_ACC:  if (w_accept && w_close) w_state_nxt = ST_FIN;
            ST_FIN:  w_state_nxt = ST_OUT;
            ST_OUT:  if (out_ready) w_state_nxt = ST_ACC;
            default: w_state_nxt = ST_ACC;
        endcase
    end

    neuron_requant u_requant (
        .acc     (r_acc),
        .bias    (r_bias),
        .acc_sat (r_sat),
        .data    (w_rq_data),
        .sat     (w_rq_sat)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_acc       <= '0;
            r_bias      <= '0;
            r_cnt       <= '0;
            r_sat       <= 1'b0;
            r_err       <= 1'b0;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_sat   <= 1'b0;
            r_out_err   <= 1'b0;
        end else begin
            // Handshake flags follow the next state so they stay pure registers.
            r_in_ready  <= (w_state_nxt == ST_ACC);
            r_out_valid <= (w_state_nxt == ST_OUT);
            if (w_accept) begin
                r_cnt <= w_cnt_nxt;
                if (w_first) begin
                    r_acc  <= w_prod_ext;
                    r_bias <= bias;
                end else begin
                    r_acc <= w_sum.sum;
                    if (w_sum.sat)
                        r_sat <= 1'b1;
                end
                if (w_limit && !in_last)
                    r_err <= 1'b1;
            end
            if (r_state == ST_FIN) begin
                r_out_data <= w_rq_data;
                r_out_sat  <= w_rq_sat;
                r_out_err  <= r_err;
            end
            if (r_state == ST_OUT && out_ready) begin
                r_sat <= 1'b0;
                r_err <= 1'b0;
                r_cnt <= '0;
            end
        end
    end

    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;
    assign out_data  = r_out_data;
    assign out_sat   = r_out_sat;
    assign out_err   = r_out_err;

endmodule

`default_nettype wire

// File: tb/tb_neuron_accum.sv
// ============================================================================
// Module      : tb_neuron_accum
// Description : Directed self-checking bench for neuron_accum.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_neuron_accum;
    import neuron_pkg::*;

    logic                          clk = 1'b0;
    logic                          rst;
    logic                          in_valid;
    logic                          in_ready;
    logic signed [XDATA_WIDTH-1:0] in_x;
    logic signed [WDATA_WIDTH-1:0] in_w;
    logic                          in_last;
    logic signed [WDATA_WIDTH-1:0] bias;
    logic                          out_valid;
    logic                          out_ready;
    logic [XDATA_WIDTH-1:0]        out_data;
    logic                          out_sat;
    logic                          out_err;

    int n_checks = 0;
    int n_fail   = 0;

`ifdef NEURON_ACC_ROUND_EN
    localparam int c_exp_round = 1;
`else
    localparam int c_exp_round = 0;
`endif

    always #5 clk = ~clk;

    neuron_accum u_dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_x      (in_x),
        .in_w      (in_w),
        .in_last   (in_last),
        .bias      (bias),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_sat   (out_sat),
        .out_err   (out_err)
    );

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Present one beat at a negedge and return at the negedge after acceptance.
    task automatic send_beat(input int x, input int w, input int b, input bit last);
        int guard;
        guard    = 0;
        in_x     = XDATA_WIDTH'(x);
        in_w     = WDATA_WIDTH'(w);
        bias     = WDATA_WIDTH'(b);
        in_last  = last;
        in_valid = 1'b1;
        while (!in_ready && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        if (!in_ready)
            check_val("accept_timeout", 32'(in_ready), 32'd1);
        @(negedge clk);
    endtask

    task automatic get_result(input string tag, input int exp_d, input bit exp_s, input bit exp_e);
        int guard;
        guard     = 0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        while (!out_valid && guard < 300) begin
            @(negedge clk);
            guard++;
        end
        check_val({tag, "_valid"}, 32'(out_valid), 32'd1);
        check_val({tag, "_data"},  32'(out_data),  32'(exp_d));
        check_val({tag, "_sat"},   32'(out_sat),   32'(exp_s));
        check_val({tag, "_err"},   32'(out_err),   32'(exp_e));
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_x      = '0;
        in_w      = '0;
        in_last   = 1'b0;
        bias      = '0;
        out_ready = 1'b0;
        repeat (3) @(negedge clk);
        check_val("rst_in_ready",  32'(in_ready),  32'd1);
        check_val("rst_out_valid", 32'(out_valid), 32'd0);
        check_val("rst_out_data",  32'(out_data),  32'd0);
        check_val("rst_out_sat",   32'(out_sat),   32'd0);
        check_val("rst_out_err",   32'(out_err),   32'd0);
        rst = 1'b0;
        @(negedge clk);

        // 1.0 * 2.0 + 0.5 = 2.5, with latency probe
        send_beat(32, 64, 16, 1'b1);
        in_valid = 1'b0;
        check_val("lat_fin_valid", 32'(out_valid), 32'd0);
        check_val("lat_fin_ready", 32'(in_ready),  32'd0);
        @(negedge clk);
        check_val("lat_out_valid", 32'(out_valid), 32'd1);
        get_result("t1", 80, 1'b0, 1'b0);

        // negative result removed by ReLU, not a saturation
        send_beat(32, -64, 0, 1'b1);
        get_result("t2_relu", 0, 1'b0, 1'b0);

        // large positive sum clipped to 511
        for (int i = 0; i < 4; i++) send_beat(511, 1023, 0, i == 3);
        get_result("t3_clip", 511, 1'b1, 1'b0);

        // sub-LSB product: rounding decides
        send_beat(1, 16, 0, 1'b1);
        get_result("t4_round", c_exp_round, 1'b0, 1'b0);

        // accumulator saturates negative: output 0 but sat still reported
        for (int i = 0; i < 17; i++) send_beat(-512, 1023, 0, i == 16);
        get_result("t5_negsat", 0, 1'b1, 1'b0);

        // accumulator saturates positive
        for (int i = 0; i < 17; i++) send_beat(-512, -1024, 0, i == 16);
        get_result("t5_possat", 511, 1'b1, 1'b0);

        // output stall with a beat waiting upstream
        for (int i = 0; i < 3; i++) send_beat(32, 32, 0, i == 2);
        in_valid = 1'b0;
        begin
            int guard;
            guard = 0;
            while (!out_valid && guard < 20) begin
                @(negedge clk);
                guard++;
            end
        end
        in_x     = XDATA_WIDTH'(32);
        in_w     = WDATA_WIDTH'(64);
        bias     = '0;
        in_last  = 1'b1;
        in_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            check_val("t6_stall_valid", 32'(out_valid), 32'd1);
            check_val("t6_stall_data",  32'(out_data),  32'd96);
            check_val("t6_stall_ready", 32'(in_ready),  32'd0);
            @(negedge clk);
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check_val("t6_post_ready", 32'(in_ready),  32'd1);
        check_val("t6_post_valid", 32'(out_valid), 32'd0);
        @(negedge clk);
        in_valid = 1'b0;
        check_val("t6_next_taken", 32'(in_ready), 32'd0);
        get_result("t6_next", 64, 1'b0, 1'b0);

        // reset mid-frame discards the partial sum
        send_beat(32, 64, 0, 1'b0);
        send_beat(32, 64, 0, 1'b0);
        in_valid = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check_val("t7_rst_ready", 32'(in_ready),  32'd1);
        check_val("t7_rst_valid", 32'(out_valid), 32'd0);
        send_beat(32, 64, 0, 1'b1);
        get_result("t7_fresh", 64, 1'b0, 1'b0);

        // MAX_TERMS beats without in_last closes with err
        for (int i = 0; i < 64; i++) send_beat(1, 1, 0, 1'b0);
        in_valid = 1'b0;
        check_val("t8_closed", 32'(in_ready), 32'd0);
        get_result("t8_maxterms", 2, 1'b0, 1'b1);

        // MAX_TERMS beats with in_last on the final one is a normal close
        for (int i = 0; i < 64; i++) send_beat(1, 1, 0, i == 63);
        get_result("t9_maxlast", 2, 1'b0, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
